// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle for keypad_scanner: row returns in,
// column drive plus key code / data-available out.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] data;
    logic       dav;

    modport master (
        input  row,
        output col,
        output data,
        output dav
    );

    modport slave (
        output row,
        input  col,
        input  data,
        input  dav
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sweep, row synchroniser,
// press/release debounce, registered key code and dav strobe.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic             clock,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int MAX_CYCLES =
        (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_DONE  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [2:0] {
        SCAN,
        DEB_PRESS,
        LATCH,
        HOLD,
        RELEASE
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    row_meta_q, row_s_q;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    data_q, data_d;
    logic          dav_q, dav_d;
    logic [1:0]    low_row;
    logic          tracked;
    logic [CW-1:0] cnt_inc;

    always_ff @(posedge clock) begin
        if (reset) begin
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
        end else begin
            row_meta_q <= kp.row;
            row_s_q    <= row_meta_q;
        end
    end

    // Several rows low in one column: the lowest index wins.
    always_comb begin
        low_row = 2'd0;
        priority case (1'b1)
            !row_s_q[0]: low_row = 2'd0;
            !row_s_q[1]: low_row = 2'd1;
            !row_s_q[2]: low_row = 2'd2;
            !row_s_q[3]: low_row = 2'd3;
            default:     low_row = 2'd0;
        endcase
    end

    assign tracked = row_s_q[row_idx_q];
    assign cnt_inc = cnt_q + ONE;

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        dav_d     = dav_q;
        unique case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    if (row_s_q != 4'hF) begin
                        row_idx_d = low_row;
                        cnt_d     = ONE;
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = LATCH;
                            data_d  = {low_row, col_idx_q};
                        end else begin
                            state_d = DEB_PRESS;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = '0;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DEB_PRESS: begin
                if (tracked) begin
                    state_d   = SCAN;
                    col_idx_d = col_idx_q + 2'd1;
                    cnt_d     = '0;
                end else if (cnt_inc == DEB_DONE) begin
                    state_d = LATCH;
                    data_d  = {row_idx_q, col_idx_q};
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LATCH: begin
                state_d = HOLD;
                dav_d   = 1'b1;
                cnt_d   = '0;
            end
            HOLD: begin
                if (tracked) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = SCAN;
                        dav_d     = 1'b0;
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = '0;
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = ONE;
                    end
                end
            end
            RELEASE: begin
                if (!tracked) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_DONE) begin
                    state_d   = SCAN;
                    dav_d     = 1'b0;
                    col_idx_d = col_idx_q + 2'd1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            cnt_q     <= '0;
            data_q    <= 4'h0;
            dav_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            dav_q     <= dav_d;
        end
    end

    assign kp.col  = ~(4'b0001 << col_idx_q);
    assign kp.data = data_q;
    assign kp.dav  = dav_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, procedural
// reference model, per-cycle compare plus directed literal checks.
module tb_keypad_scanner;
    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys  = '0;
    logic [3:0]  row_w;
    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_CYCLES    (SCAN),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clock = ~clock;

    // Key (r,c) pressed pulls row r low while column c is driven.
    always_comb begin
        row_w = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.col[c]) row_w[r] = 1'b0;
    end
    assign kp.row = row_w;

    function automatic logic [3:0] col_of(int c);
        logic [3:0] v;
        v = 4'hF;
        v[2'(c)] = 1'b0;
        return v;
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sequential story of scan, debounce, hold.
    logic [3:0] h1 = 4'hF;
    logic [3:0] h2 = 4'hF;
    logic [3:0] m_rs;
    logic [3:0] m_col  = 4'b1110;
    logic [3:0] m_data = 4'h0;
    logic       m_dav  = 1'b0;
    bit         m_hit  = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            h1 <= 4'hF;
            h2 <= 4'hF;
        end else begin
            h1 <= row_w;
            h2 <= h1;
        end
    end

    task automatic tick();
        @(posedge clock);
        m_rs = h2;
        if (reset) m_hit = 1'b1;
    endtask

    task automatic run_model();
        int c;
        int r;
        int run;
        bit ok;
        c = 0;
        m_col = col_of(0);
        forever begin
            for (int k = 0; k < SCAN; k++) begin
                tick();
                if (m_hit) return;
            end
            if (m_rs == 4'hF) begin
                c = (c + 1) % 4;
                m_col = col_of(c);
                continue;
            end
            r = 0;
            for (int i = 3; i >= 0; i--) if (!m_rs[i]) r = i;
            ok = 1'b1;
            for (int k = 1; k < DEB; k++) begin
                tick();
                if (m_hit) return;
                if (m_rs[r]) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (!ok) begin
                c = (c + 1) % 4;
                m_col = col_of(c);
                continue;
            end
            m_data = 4'(r * 4 + c);
            tick();
            if (m_hit) return;
            m_dav = 1'b1;
            run = 0;
            while (run < DEB) begin
                tick();
                if (m_hit) return;
                run = m_rs[r] ? run + 1 : 0;
            end
            m_dav = 1'b0;
            c = (c + 1) % 4;
            m_col = col_of(c);
        end
    endtask

    initial begin
        forever begin
            m_hit = 1'b0;
            run_model();
            m_col  = 4'b1110;
            m_data = 4'h0;
            m_dav  = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_col", kp.col, m_col);
            chk("model_data", kp.data, m_data);
            chk("model_dav", {3'b0, kp.dav}, {3'b0, m_dav});
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_col(string name, logic [3:0] v, int budget);
        int n = 0;
        while (kp.col != v && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(name, kp.col, v);
    endtask

    task automatic wait_data(string name, logic [3:0] v, int budget);
        int n = 0;
        while (kp.data != v && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(name, kp.data, v);
    endtask

    task automatic wait_dav(string name, logic v, int budget);
        int n = 0;
        while (kp.dav != v && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(name, {3'b0, kp.dav}, {3'b0, v});
    endtask

    initial begin
        cyc(2);
        chk("rst_col", kp.col, 4'b1110);
        chk("rst_dav", {3'b0, kp.dav}, 4'h0);
        chk("rst_data", kp.data, 4'h0);
        chk_en = 1'b1;
        reset  = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            chk("idle_col", kp.col, col_of((k / 4) % 4));
            cyc(1);
        end

        keys = 16'h0200;
        wait_data("press_data", 4'h9, 120);
        chk("press_dav_lo", {3'b0, kp.dav}, 4'h0);
        cyc(1);
        chk("press_dav_hi", {3'b0, kp.dav}, 4'h1);
        cyc(60);
        chk("held_dav", {3'b0, kp.dav}, 4'h1);
        chk("held_data", kp.data, 4'h9);
        keys = 16'h0000;
        cyc(9);
        chk("rel_dav_9", {3'b0, kp.dav}, 4'h1);
        cyc(1);
        chk("rel_dav_10", {3'b0, kp.dav}, 4'h0);
        chk("rel_data", kp.data, 4'h9);

        wait_col("to_col3", 4'b0111, 40);
        keys = 16'h0008;
        cyc(7);
        keys = 16'h0000;
        wait_col("bounce_col", 4'b1110, 40);
        cyc(20);
        chk("bounce_dav", {3'b0, kp.dav}, 4'h0);
        chk("bounce_data", kp.data, 4'h9);

        keys = 16'h0004;
        wait_dav("rb_dav_up", 1'b1, 120);
        chk("rb_data", kp.data, 4'h2);
        cyc(5);
        keys = 16'h0000;
        cyc(5);
        keys = 16'h0004;
        cyc(2);
        chk("rb_dav_mid", {3'b0, kp.dav}, 4'h1);
        keys = 16'h0000;
        cyc(9);
        chk("rb_dav_9", {3'b0, kp.dav}, 4'h1);
        cyc(1);
        chk("rb_dav_10", {3'b0, kp.dav}, 4'h0);

        keys = 16'h4040;
        wait_dav("prio_dav", 1'b1, 120);
        chk("prio_data", kp.data, 4'h6);
        keys = 16'h0000;
        wait_dav("prio_rel", 1'b0, 40);

        keys = 16'h1000;
        wait_dav("hold_dav", 1'b1, 120);
        chk("hold_data", kp.data, 4'hC);
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_dav", {3'b0, kp.dav}, 4'h0);
        chk("mid_rst_data", kp.data, 4'h0);
        chk("mid_rst_col", kp.col, 4'b1110);
        reset = 1'b0;
        cyc(10);
        chk("redet_pre", kp.data, 4'h0);
        cyc(1);
        chk("redet_data", kp.data, 4'hC);
        chk("redet_dav_lo", {3'b0, kp.dav}, 4'h0);
        cyc(1);
        chk("redet_dav_hi", {3'b0, kp.dav}, 4'h1);
        keys = 16'h0000;
        wait_dav("final_rel", 1'b0, 40);
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, synchronises and debounces the row returns, and presents a 4-bit key code with a data-available strobe. Sits directly upstream of the control unit: `data` drives its `DataIn[3:0]`, and `dav` drives its `dav`. `data` is guaranteed stable one cycle before every `dav` rising edge.

## Interface
- `SCAN_CYCLES`, 4: clock cycles each column is driven during scanning; must be ≥ 3.
- `DEBOUNCE_CYCLES`, 8: consecutive identical samples required to accept a press or a release; must be ≥ 1.

- `clock`  in  1  system clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `row`  in  4  keypad row returns, active-low (pulled up externally), asynchronous.
- `col`  out  4  column drive, active-low, exactly one bit low at all times.
- `data`  out  4  key code {row_index[1:0], col_index[1:0]}; holds last accepted key.
- `dav`  out  1  high from key accepted until release debounced.

## Operation
- `row` passes through a 2-flop synchroniser (reset value 4'b1111) → `row_s`. All decisions use `row_s`.
- States:
  - SCAN: drive column `c` (`col = ~(1<<c)`) for `SCAN_CYCLES` cycles. On the last cycle of the window (scan count = `SCAN_CYCLES-1`), sample `row_s`.
    - If any bit is low, capture the lowest-index low row as `r`, set debounce count = 1, and go to DEB_PRESS.
    - Otherwise advance `c` (3 wraps to 0) and restart the window.
  - DEB_PRESS: `col` frozen. Each cycle, if `row_s[r]` = 0, increment the count; when it reaches `DEBOUNCE_CYCLES`, go to LATCH. If `row_s[r]` = 1 at any point, go to SCAN at column `c+1` with no output change.
  - LATCH: one cycle. `data <= {r, c}` on entry; `dav` stays 0. Then go to HOLD.
  - HOLD: `dav` = 1 and `col` frozen. When `row_s[r]` = 1, go to RELEASE with count = 1.
  - RELEASE: `dav` stays 1. Each cycle, if `row_s[r]` = 1, increment; when the count reaches `DEBOUNCE_CYCLES`, `dav` → 0 and go to SCAN at column `c+1`. If `row_s[r]` = 0, return to HOLD and clear the count.
- Only tracked row `r` matters outside SCAN. Other rows going low during DEB_PRESS, LATCH, HOLD or RELEASE are ignored.
- Multiple keys in the same column: lowest row index wins. Keys in other columns are not seen until scanning resumes.
- `dav` and `data` are registered outputs; there are no combinational paths from `row`.
- Counter widths are sized for max(`SCAN_CYCLES`, `DEBOUNCE_CYCLES`); counters never wrap within a state.

## Timing
- Reset values: state SCAN, `c` = 0, `col` = 4'b1110, `data` = 4'h0, `dav` = 0, counters 0, synchroniser 4'b1111. Reset mid-operation (any state) returns to these values at the next edge; the key in progress is discarded.
- Column window is `SCAN_CYCLES` cycles; a full scan is 4·`SCAN_CYCLES` cycles.
- Synchroniser latency is 2 cycles: `row` → `row_s`.
- Press acceptance: the scan sample counts as sample 1. After `DEBOUNCE_CYCLES-1` further low cycles the FSM enters LATCH.
  - `data` changes on LATCH entry.
  - `dav` rises exactly 1 cycle later.
- Release: `dav` falls on the edge where the `DEBOUNCE_CYCLES`-th consecutive high `row_s[r]` sample is counted. Scanning resumes the same cycle at the next column, with a full window.
- Minimum `dav` high time is `DEBOUNCE_CYCLES` cycles.
- `data` never changes while `dav` = 1.

## Test plan
- Reset / idle scan: assert `reset` 2 cycles, `row` = 4'b1111 → `col` = 1110, `dav` = 0, `data` = 0. `col` then steps 1110→1101→1011→0111→1110, each for exactly 4 cycles.
- Clean press: `row[2]` low whenever `col[1]` is low, held 60 cycles → `data` = 4'b1001, `dav` rises 1 cycle later and stays high while held. After release, `dav` falls 8 cycles after `row_s[2]` goes high, and `data` stays 9.
- Press bounce: `row[0]` low at a `col[3]` sample, then high 3 cycles later → `dav` stays 0 and `data` is unchanged. Scan resumes at `col` = 1110.
- Release bounce: while in HOLD, `row[r]` goes high 5 cycles, low 2, then high 10 → `dav` stays 1 through the bounce and falls exactly 8 cycles into the final high run.
- Priority: `row[1]` and `row[3]` both low on `col[2]` → `data` = 4'b0110.
- Reset mid-HOLD: `reset` asserted while `dav` = 1 → next edge `dav` = 0, `data` = 0, `col` = 1110. With the key still held, it is re-detected after the next column-0 sample plus debounce.
